// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer arbiter: video scan-out reads win every slot they need,
// CPU register-bus reads/writes fill the gaps. Optional macro: FB_CPU_READ_EN.
module vga_fb_arbiter #(
  parameter int PIX_BITS = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [4:0]          x_pos,
  input  logic [3:0]          y_pos,
  input  logic                blank,
  input  logic                cpu_req,
  input  logic                cpu_we,
  input  logic [8:0]          cpu_addr,
  input  logic [PIX_BITS-1:0] cpu_wdata,
  output logic                cpu_ack,
  output logic [PIX_BITS-1:0] cpu_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [8:0]          mem_addr,
  output logic [PIX_BITS-1:0] mem_wdata,
  input  logic [PIX_BITS-1:0] mem_rdata,
  output logic [PIX_BITS-1:0] pix_out,
  output logic                pix_blank
);

  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_ISSUE_WAIT = 2'd1;
  localparam logic [1:0] ST_DATA       = 2'd2;
  localparam logic [1:0] ST_ACK        = 2'd3;

  logic [8:0]          pos_q;
  logic                blank_q;
  logic [2:0]          blank_dly_q;
  logic [1:0]          state_q, state_d;
  logic                mem_en_q, mem_we_q;
  logic [8:0]          mem_addr_q;
  logic [PIX_BITS-1:0] mem_wdata_q;
  logic [PIX_BITS-1:0] pix_q;
  logic                cpu_ack_q;
  logic [1:0]          tag_vld_q;
  logic [8:0]          cur_pos;
  logic                trigger, grant, cpu_issue;

  assign cur_pos = {y_pos, x_pos};
  // A new visible cell, or the first cell after blank falls, needs a fetch.
  assign trigger = !blank && ((cur_pos != pos_q) || blank_q);
  assign grant   = (state_q == ST_IDLE) && cpu_req && !trigger;

`ifdef FB_CPU_READ_EN
  assign cpu_issue = grant;
`else
  // Reads are acknowledged on the normal timeline but never touch the RAM.
  assign cpu_issue = grant && cpu_we;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:       if (grant) state_d = ST_ISSUE_WAIT;
      ST_ISSUE_WAIT: state_d = ST_DATA;
      ST_DATA:       state_d = ST_ACK;
      ST_ACK:        state_d = ST_IDLE;
      default:       state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_q       <= '0;
      blank_q     <= 1'b1;
      blank_dly_q <= 3'b111;
      state_q     <= ST_IDLE;
      cpu_ack_q   <= 1'b0;
    end else begin
      pos_q       <= cur_pos;
      blank_q     <= blank;
      blank_dly_q <= {blank_dly_q[1:0], blank};
      state_q     <= state_d;
      cpu_ack_q   <= (state_q == ST_DATA);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else if (trigger) begin
      mem_en_q   <= 1'b1;
      mem_we_q   <= 1'b0;
      mem_addr_q <= cur_pos;
    end else if (cpu_issue) begin
      mem_en_q    <= 1'b1;
      mem_we_q    <= cpu_we;
      mem_addr_q  <= cpu_addr;
      mem_wdata_q <= cpu_wdata;
    end else begin
      mem_en_q <= 1'b0;
      mem_we_q <= 1'b0;
    end
  end

`ifdef FB_CPU_READ_EN
  // Owner bit travels with each read so returning data lands in the right place.
  logic [1:0]          tag_cpu_q;
  logic [PIX_BITS-1:0] cpu_rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_vld_q   <= '0;
      tag_cpu_q   <= '0;
      pix_q       <= '0;
      cpu_rdata_q <= '0;
    end else begin
      tag_vld_q <= {tag_vld_q[0], trigger || (cpu_issue && !cpu_we)};
      tag_cpu_q <= {tag_cpu_q[0], !trigger};
      if (tag_vld_q[1] && !tag_cpu_q[1]) pix_q <= mem_rdata;
      if (tag_vld_q[1] && tag_cpu_q[1]) cpu_rdata_q <= mem_rdata;
    end
  end

  assign cpu_rdata = cpu_rdata_q;
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_vld_q <= '0;
      pix_q     <= '0;
    end else begin
      tag_vld_q <= {tag_vld_q[0], trigger};
      if (tag_vld_q[1]) pix_q <= mem_rdata;
    end
  end

  assign cpu_rdata = '0;
`endif

  assign cpu_ack   = cpu_ack_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign pix_out   = pix_q;
  assign pix_blank = blank_dly_q[2];

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Randomized self-checking bench for vga_fb_arbiter against a cycle-scheduled
// transaction model; honours FB_CPU_READ_EN the same way as the design.
module tb_vga_fb_arbiter;
  localparam int PB   = 6;
  localparam int MAXC = 4096;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [4:0]    x_pos = '0;
  logic [3:0]    y_pos = '0;
  logic          blank = 1'b1;
  logic          cpu_req = 1'b0;
  logic          cpu_we = 1'b0;
  logic [8:0]    cpu_addr = '0;
  logic [PB-1:0] cpu_wdata = '0;
  logic          cpu_ack;
  logic [PB-1:0] cpu_rdata;
  logic          mem_en, mem_we;
  logic [8:0]    mem_addr;
  logic [PB-1:0] mem_wdata;
  logic [PB-1:0] mem_rdata;
  logic [PB-1:0] pix_out;
  logic          pix_blank;

  vga_fb_arbiter #(.PIX_BITS(PB)) dut (
    .clk(clk), .rst_n(rst_n), .x_pos(x_pos), .y_pos(y_pos), .blank(blank),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .pix_out(pix_out), .pix_blank(pix_blank)
  );

  always #5 clk = ~clk;

  function automatic logic [PB-1:0] init_pix(int i);
    return PB'((i * 37 + 11) ^ (i >> 3));
  endfunction

  // Framebuffer RAM: registered read, contents preloaded on the first edge.
  logic [PB-1:0] ram [512];
  logic [PB-1:0] ram_rd_q = '0;
  logic          ram_loaded = 1'b0;
  always @(posedge clk) begin
    if (!ram_loaded) begin
      for (int i = 0; i < 512; i++) ram[i] <= init_pix(i);
      ram_loaded <= 1'b1;
    end else if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else ram_rd_q <= ram[mem_addr];
    end
  end
  assign mem_rdata = ram_rd_q;

  int n_checks = 0;
  int n_err = 0;
  int cyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: expectations scheduled per cycle index.
  bit            e_en [MAXC];
  bit            e_we [MAXC];
  logic [8:0]    e_addr [MAXC];
  logic [PB-1:0] e_wd [MAXC];
  bit            e_ack [MAXC];
  logic [PB-1:0] e_rd [MAXC];
  bit            p_upd [MAXC];
  logic [PB-1:0] p_val [MAXC];
  bit            e_pb [MAXC];
  logic [PB-1:0] mram [512];
  logic [8:0]    m_prev_pos;
  bit            m_prev_blank;
  int            m_free;
  int            m_ack_at;
  logic [PB-1:0] m_pix;
  logic [PB-1:0] m_rdata;

  task automatic model_clear();
    for (int i = cyc; i < MAXC; i++) begin
      e_en[i] = 0; e_we[i] = 0; e_ack[i] = 0; p_upd[i] = 0; e_pb[i] = 0;
    end
    for (int k = 0; k < 3; k++) e_pb[cyc + k] = 1;
    m_prev_pos = '0;
    m_prev_blank = 1;
    m_free = cyc;
    m_ack_at = -10;
    m_pix = '0;
    m_rdata = '0;
  endtask

  // Decide what this cycle's inputs must produce in later cycles.
  task automatic decide();
    int c;
    logic [8:0] p;
    bit trig;
    c = cyc;
    p = {y_pos, x_pos};
    trig = !blank && ((p != m_prev_pos) || m_prev_blank);
    m_prev_pos = p;
    m_prev_blank = blank;
    e_pb[c + 3] = blank;
    if (trig) begin
      e_en[c + 1] = 1; e_we[c + 1] = 0; e_addr[c + 1] = p;
      p_upd[c + 3] = 1; p_val[c + 3] = mram[p];
    end else if (cpu_req && c >= m_free) begin
      m_free = c + 4;
      m_ack_at = c + 3;
      e_ack[c + 3] = 1;
      if (cpu_we) begin
        e_en[c + 1] = 1; e_we[c + 1] = 1;
        e_addr[c + 1] = cpu_addr; e_wd[c + 1] = cpu_wdata;
        mram[cpu_addr] = cpu_wdata;
      end else begin
`ifdef FB_CPU_READ_EN
        e_en[c + 1] = 1; e_we[c + 1] = 0; e_addr[c + 1] = cpu_addr;
        m_rdata = mram[cpu_addr];
`endif
      end
      e_rd[c + 3] = m_rdata;
      $display("cpu txn cycle=%0d we=%0d addr=0x%03h wdata=0x%02h expect_rdata=0x%02h",
               c, cpu_we, cpu_addr, cpu_wdata, m_rdata);
    end
  endtask

  task automatic verify();
    int c;
    c = cyc;
    if (p_upd[c]) m_pix = p_val[c];
    check("mem_en", 32'(mem_en), 32'(e_en[c]));
    check("mem_we", 32'(mem_we), 32'(e_we[c]));
    if (e_en[c]) check("mem_addr", 32'(mem_addr), 32'(e_addr[c]));
    if (e_en[c] && e_we[c]) check("mem_wdata", 32'(mem_wdata), 32'(e_wd[c]));
    check("cpu_ack", 32'(cpu_ack), 32'(e_ack[c]));
    if (e_ack[c]) check("cpu_rdata", 32'(cpu_rdata), 32'(e_rd[c]));
    check("pix_out", 32'(pix_out), 32'(m_pix));
    check("pix_blank", 32'(pix_blank), 32'(e_pb[c]));
  endtask

  task automatic tick();
    decide();
    @(negedge clk);
    verify();
    @(posedge clk);
    #1;
    cyc++;
    if (cpu_req && cyc == m_ack_at + 1) cpu_req = 1'b0;
  endtask

  task automatic cpu_start(input logic we, input logic [8:0] addr, input logic [PB-1:0] wd);
    cpu_req = 1'b1;
    cpu_we = we;
    cpu_addr = addr;
    cpu_wdata = wd;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cpu_ack"}, 32'(cpu_ack), 32'd0);
    check({tag, "_cpu_rdata"}, 32'(cpu_rdata), 32'd0);
    check({tag, "_mem_en"}, 32'(mem_en), 32'd0);
    check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
    check({tag, "_pix_out"}, 32'(pix_out), 32'd0);
    check({tag, "_pix_blank"}, 32'(pix_blank), 32'd1);
  endtask

  initial begin
    int vhold;
    for (int i = 0; i < 512; i++) mram[i] = init_pix(i);

    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    cyc = 0;
    model_clear();

    // First visible cells on row 2, then column 0 -> 1.
    blank = 1'b0; y_pos = 4'd2; x_pos = 5'd0;
    repeat (2) tick();
    x_pos = 5'd1;
    repeat (4) tick();

    // CPU write then read-back in idle video.
    blank = 1'b1;
    repeat (3) tick();
    cpu_start(1'b1, 9'h1A5, 6'h2B);
    repeat (6) tick();
    cpu_start(1'b0, 9'h1A5, 6'h00);
    repeat (6) tick();

    // CPU request collides with a coordinate change: video goes first.
    blank = 1'b0; x_pos = 5'd3; y_pos = 4'd13;
    repeat (3) tick();
    x_pos = 5'd5;
    cpu_start(1'b0, 9'h1A5, 6'h00);
    repeat (8) tick();

    // Blank sweep, then blank falls at column 0.
    blank = 1'b1;
    for (int x = 0; x < 32; x++) begin
      x_pos = 5'(x);
      repeat (2) tick();
    end
    x_pos = 5'd0;
    blank = 1'b0;
    repeat (5) tick();

    // Reset asserted while a CPU read sits in ISSUE_WAIT.
    blank = 1'b1;
    repeat (3) tick();
    cpu_start(1'b0, 9'h010, 6'h00);
    tick();
    check("grant_before_reset", 32'(m_ack_at), 32'(cyc + 2));
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(posedge clk);
    @(posedge clk);
    #1;
    cyc += 2;
    rst_n = 1'b1;
    cpu_req = 1'b0;
    model_clear();
    repeat (6) tick();

    // Randomized traffic.
    vhold = 0;
    while (cyc < 1900) begin
      if (vhold >= 2 && $urandom_range(0, 2) == 0) begin
        if ($urandom_range(0, 1) == 0) x_pos = x_pos + 5'd1;
        else {y_pos, x_pos} = 9'($urandom_range(0, 511));
        vhold = 0;
      end else if (vhold >= 2 && $urandom_range(0, 29) == 0) begin
        blank = ~blank;
        vhold = 0;
      end
      if (!cpu_req && $urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 1) == 0)
          cpu_start(1'($urandom_range(0, 1)), {y_pos, x_pos}, PB'($urandom));
        else
          cpu_start(1'($urandom_range(0, 1)), 9'($urandom_range(0, 511)), PB'($urandom));
      end
      tick();
      vhold++;
    end
    cpu_req = 1'b0;
    blank = 1'b1;
    repeat (6) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
